fetch_pc_ctrl: RTL and testbench
================================

Name: fetch_pc_ctrl

Overview:
- Upstream neighbour of the fetch stage. Owns the architectural fetch PC and drives the instruction-bus request.
- Guarantees the request stays stable until data_ok, and buffers one returned instruction until decode accepts it.
- Squashes wrong-path fetches on redirects from execute.
- Sequences instruction fetches against data-bus activity through hold_fetch.

Parameters:
RESET_PC, 64'h8000_0000, PC of the first fetch after reset.

Ports:
clk  input  1  clock, rising edge
resetn  input  1  asynchronous active-low reset
ireq  output  ibus_req_t  instruction bus request (valid, addr, size)
iresp  input  ibus_resp_t  instruction bus response (data_ok, data)
hold_fetch  input  1  load/store owns the memory path; do not start a new fetch
redirect_valid  input  1  branch/jump/exception redirect from execute
redirect_pc  input  64  redirect target; bits [1:0] ignored (forced 0)
out_valid  output  1  fetched instruction available to decode
out_ready  input  1  decode accepts this cycle
out_pc  output  64  PC of presented instruction
out_instr  output  32  presented instruction

Behaviour:
- Registers:
  - pc_q: next PC to fetch.
  - req_pc: address of the outstanding request.
  - buf_pc / buf_instr: buffered result.
  - kill: flag marking the outstanding request as wrong-path.
  - state: IDLE / REQ / HOLD.
- Reset (async, resetn=0): state=IDLE, pc_q=RESET_PC, req_pc=RESET_PC, kill=0, buf=0. Outputs: ireq.valid=0, ireq.addr=RESET_PC, out_valid=0, out_pc=RESET_PC, out_instr=0. Reset mid-request abandons the request with no response tracking.
- ireq.valid=1 iff state==REQ. While REQ: ireq.addr=req_pc and ireq.size=MSIZE4, both held constant until the data_ok cycle inclusive.
- IDLE:
  - redirect_valid -> pc_q<=redirect_pc, stay IDLE. Redirect has priority over issue.
  - else !hold_fetch -> req_pc<=pc_q, state<=REQ.
  - else stay.
- REQ:
  - data_ok & (kill | redirect_valid) -> discard data, kill<=0, state<=IDLE. If redirect_valid, also pc_q<=redirect_pc.
  - data_ok & !kill & !redirect_valid -> buf_pc<=req_pc, buf_instr<=iresp.data[31:0], pc_q<=req_pc+4 (64-bit wrap), state<=HOLD.
  - !data_ok & redirect_valid -> pc_q<=redirect_pc, kill<=1, request stays asserted. A later redirect overwrites pc_q (last wins).
  - hold_fetch is ignored once in REQ.
- HOLD:
  - out_valid = (state==HOLD) & !redirect_valid. The redirect mask is combinational.
  - out_pc=buf_pc, out_instr=buf_instr.
  - redirect_valid -> drop buffer, pc_q<=redirect_pc, state<=IDLE. Redirect wins over out_ready.
  - out_ready & !redirect_valid -> if !hold_fetch: req_pc<=pc_q, state<=REQ; else state<=IDLE.
  - else hold; buffer contents stable.
- out_pc/out_instr hold last buffered values outside HOLD; only out_valid is qualified.
- Throughput: at most one instruction per 2 cycles plus bus latency; no speculative second request.
- Zero-latency bus (data_ok in first REQ cycle): legal; data is captured that edge.

Decomposition:
- Package pipes:
  - fetch_state_t enum {IDLE, REQ, HOLD}.
  - Reuse u64, u32, ibus_req_t, ibus_resp_t, MSIZE4 from common.
  - Add localparam PC_STEP = 64'd4.
- No sub-module. Single always_ff for registers plus one always_comb for next-state and outputs. No latches.

Test Plan:
- Release resetn, iresp.data_ok=1 whenever valid, out_ready=1 -> ireq.addr sequence 0x8000_0000, 0x8000_0004, 0x8000_0008; out_pc matches; out_instr equals bus data.
- Bus holds data_ok=0 for 5 cycles -> ireq.valid=1 and ireq.addr=0x8000_0000 stable all 5 cycles; one out_valid pulse after data_ok.
- Redirect to 0x8000_0100 in cycle 2 of a 4-cycle wait at 0x8000_0004 -> addr stays 0x8000_0004 until data_ok; data discarded (no out_valid); next request addr 0x8000_0100.
- HOLD with out_ready=0 for 3 cycles, then redirect_valid & out_ready together -> out_valid=0 that cycle; next fetch at redirect target; buffered instruction never consumed.
- hold_fetch=1 in IDLE for 4 cycles -> ireq.valid=0 throughout; request issues the cycle after hold_fetch falls. Redirect 0x8000_0203 -> fetch at 0x8000_0200.
- Assert resetn=0 mid-REQ -> ireq.valid and out_valid drop immediately (asynchronously); after release, first fetch at 0x8000_0000.

Source files
------------

// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared types for the fetch PC controller: bus request/response records,
// access sizes and the fetch state encoding.
package fetch_pc_ctrl_pkg;

   typedef logic [63:0] u64;
   typedef logic [31:0] u32;

   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2,
      MSIZE8 = 2'd3
   } msize_t;

   typedef struct packed {
      logic   valid;
      u64     addr;
      msize_t size;
   } ibus_req_t;

   typedef struct packed {
      logic data_ok;
      u32   data;
   } ibus_resp_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } fetch_state_t;

   localparam u64 PC_STEP = 64'd4;

   // Fetch targets are word aligned; low address bits of a redirect are dropped.
   function automatic u64 align_pc(input u64 pc);
      return {pc[63:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Instruction bus between the fetch PC controller (master) and memory (slave).
interface fetch_pc_ctrl_if;
   import fetch_pc_ctrl_pkg::*;

   ibus_req_t  ireq;
   ibus_resp_t iresp;

   modport master (output ireq, input iresp);
   modport slave  (input ireq, output iresp);

endinterface

// File: rtl/fetch_pc_ctrl.sv
// Owns the fetch PC, issues one instruction fetch at a time, buffers the
// returned instruction for decode and squashes wrong-path fetches.
module fetch_pc_ctrl
   import fetch_pc_ctrl_pkg::*;
#(
   parameter u64 RESET_PC = 64'h8000_0000
) (
   input  logic               clk,
   input  logic               resetn,
   fetch_pc_ctrl_if.master    ibus,
   input  logic               hold_fetch,
   input  logic               redirect_valid,
   input  logic [63:0]        redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [63:0]        out_pc,
   output logic [31:0]        out_instr
);

   fetch_state_t state_q, state_d;
   u64           pc_q, pc_d;
   u64           req_pc_q, req_pc_d;
   u64           buf_pc_q, buf_pc_d;
   u32           buf_instr_q, buf_instr_d;
   logic         kill_q, kill_d;

   u64           redir_target;
   logic         data_ok;
   ibus_req_t    req;

   assign redir_target = align_pc(redirect_pc);
   assign data_ok      = ibus.iresp.data_ok;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         req_pc_q    <= RESET_PC;
         buf_pc_q    <= RESET_PC;
         buf_instr_q <= '0;
         kill_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_pc_q    <= req_pc_d;
         buf_pc_q    <= buf_pc_d;
         buf_instr_q <= buf_instr_d;
         kill_q      <= kill_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_pc_d    = req_pc_q;
      buf_pc_d    = buf_pc_q;
      buf_instr_d = buf_instr_q;
      kill_d      = kill_q;

      unique case (state_q)
         IDLE: begin
            if (redirect_valid) begin
               pc_d = redir_target;
            end else if (!hold_fetch) begin
               req_pc_d = pc_q;
               state_d  = REQ;
            end
         end

         REQ: begin
            // The request cannot be withdrawn; a redirect before data_ok only
            // marks it wrong-path so its data is dropped on arrival.
            if (data_ok) begin
               if (kill_q || redirect_valid) begin
                  kill_d  = 1'b0;
                  state_d = IDLE;
                  if (redirect_valid) begin
                     pc_d = redir_target;
                  end
               end else begin
                  buf_pc_d    = req_pc_q;
                  buf_instr_d = ibus.iresp.data;
                  pc_d        = req_pc_q + PC_STEP;
                  state_d     = HOLD;
               end
            end else if (redirect_valid) begin
               pc_d   = redir_target;
               kill_d = 1'b1;
            end
         end

         HOLD: begin
            if (redirect_valid) begin
               pc_d    = redir_target;
               state_d = IDLE;
            end else if (out_ready) begin
               if (!hold_fetch) begin
                  req_pc_d = pc_q;
                  state_d  = REQ;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      req       = '0;
      req.valid = (state_q == REQ);
      req.addr  = req_pc_q;
      req.size  = MSIZE4;

      ibus.ireq = req;
      out_valid = (state_q == HOLD) && !redirect_valid;
      out_pc    = buf_pc_q;
      out_instr = buf_instr_q;
   end

   logic unused_redirect_lsbs;
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: a cycle-by-cycle vector table followed by
// hand-written sequences for reset mid-request, long bus waits and hold_fetch.
module tb_fetch_pc_ctrl;
   import fetch_pc_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic        hold_fetch;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_pc;
   logic [31:0] out_instr;

   fetch_pc_ctrl_if ibus();

   fetch_pc_ctrl #(.RESET_PC(64'h8000_0000)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .ibus           (ibus),
      .hold_fetch     (hold_fetch),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        dok;
      logic [31:0] data;
      logic        hold;
      logic        rv;
      logic [63:0] rpc;
      logic        ordy;
      logic        e_v;
      logic [63:0] e_addr;
      logic        e_ov;
      logic [63:0] e_opc;
      logic [31:0] e_oi;
   } vec_t;

   vec_t vq[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic add(input logic dok, input logic [31:0] data, input logic hold,
                      input logic rv, input logic [63:0] rpc, input logic ordy,
                      input logic e_v, input logic [63:0] e_addr, input logic e_ov,
                      input logic [63:0] e_opc, input logic [31:0] e_oi);
      vec_t v;
      v.dok = dok; v.data = data; v.hold = hold; v.rv = rv; v.rpc = rpc; v.ordy = ordy;
      v.e_v = e_v; v.e_addr = e_addr; v.e_ov = e_ov; v.e_opc = e_opc; v.e_oi = e_oi;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic dok, input logic [31:0] data, input logic hold,
                        input logic rv, input logic [63:0] rpc, input logic ordy);
      ibus.iresp.data_ok = dok;
      ibus.iresp.data    = data;
      hold_fetch         = hold;
      redirect_valid     = rv;
      redirect_pc        = rpc;
      out_ready          = ordy;
   endtask

   task automatic chk_bus(input string tag, input int idx, input logic e_v,
                          input logic [63:0] e_addr);
      chk({tag, ".ireq_valid"}, idx, 64'(ibus.ireq.valid), 64'(e_v));
      chk({tag, ".ireq_addr"}, idx, ibus.ireq.addr, e_addr);
      if (e_v) chk({tag, ".ireq_size"}, idx, 64'(ibus.ireq.size), 64'(MSIZE4));
   endtask

   localparam logic [63:0] WRAP = 64'hFFFF_FFFF_FFFF_FFFC;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // dok data hold rv rpc ordy | ireq.valid ireq.addr out_valid out_pc out_instr
      add(0, 32'h0,        0, 0, 64'h0,          1, 0, 64'h8000_0000, 0, 64'h8000_0000, 32'h0);
      add(1, 32'h1111_1111, 0, 0, 64'h0,         1, 1, 64'h8000_0000, 0, 64'h8000_0000, 32'h0);
      add(0, 32'h0,        0, 0, 64'h0,          1, 0, 64'h8000_0000, 1, 64'h8000_0000, 32'h1111_1111);
      add(1, 32'h2222_2222, 0, 0, 64'h0,         1, 1, 64'h8000_0004, 0, 64'h8000_0000, 32'h1111_1111);
      add(0, 32'h0,        0, 0, 64'h0,          1, 0, 64'h8000_0004, 1, 64'h8000_0004, 32'h2222_2222);
      add(1, 32'h3333_3333, 0, 0, 64'h0,         1, 1, 64'h8000_0008, 0, 64'h8000_0004, 32'h2222_2222);
      add(0, 32'h0,        0, 0, 64'h0,          0, 0, 64'h8000_0008, 1, 64'h8000_0008, 32'h3333_3333);
      add(0, 32'h0,        0, 0, 64'h0,          0, 0, 64'h8000_0008, 1, 64'h8000_0008, 32'h3333_3333);
      add(0, 32'h0,        0, 0, 64'h0,          0, 0, 64'h8000_0008, 1, 64'h8000_0008, 32'h3333_3333);
      add(0, 32'h0,        0, 1, 64'h8000_0100,  1, 0, 64'h8000_0008, 0, 64'h8000_0008, 32'h3333_3333);
      add(0, 32'h0,        0, 0, 64'h0,          1, 0, 64'h8000_0008, 0, 64'h8000_0008, 32'h3333_3333);
      add(0, 32'h0,        0, 0, 64'h0,          1, 1, 64'h8000_0100, 0, 64'h8000_0008, 32'h3333_3333);
      add(0, 32'h0,        0, 0, 64'h0,          1, 1, 64'h8000_0100, 0, 64'h8000_0008, 32'h3333_3333);
      add(0, 32'h0,        0, 1, 64'h8000_0203,  1, 1, 64'h8000_0100, 0, 64'h8000_0008, 32'h3333_3333);
      add(0, 32'h0,        0, 0, 64'h0,          1, 1, 64'h8000_0100, 0, 64'h8000_0008, 32'h3333_3333);
      add(1, 32'hDEAD_BEEF, 0, 0, 64'h0,         1, 1, 64'h8000_0100, 0, 64'h8000_0008, 32'h3333_3333);
      add(0, 32'h0,        0, 0, 64'h0,          1, 0, 64'h8000_0100, 0, 64'h8000_0008, 32'h3333_3333);
      add(1, 32'h4444_4444, 0, 0, 64'h0,         1, 1, 64'h8000_0200, 0, 64'h8000_0008, 32'h3333_3333);
      add(0, 32'h0,        1, 0, 64'h0,          1, 0, 64'h8000_0200, 1, 64'h8000_0200, 32'h4444_4444);
      add(0, 32'h0,        1, 0, 64'h0,          1, 0, 64'h8000_0200, 0, 64'h8000_0200, 32'h4444_4444);
      add(0, 32'h0,        0, 0, 64'h0,          1, 0, 64'h8000_0200, 0, 64'h8000_0200, 32'h4444_4444);
      add(0, 32'h0,        1, 0, 64'h0,          1, 1, 64'h8000_0204, 0, 64'h8000_0200, 32'h4444_4444);
      add(1, 32'h5555_5555, 0, 1, 64'h8000_0300, 1, 1, 64'h8000_0204, 0, 64'h8000_0200, 32'h4444_4444);
      add(0, 32'h0,        0, 0, 64'h0,          1, 0, 64'h8000_0204, 0, 64'h8000_0200, 32'h4444_4444);
      add(1, 32'h6666_6666, 0, 0, 64'h0,         1, 1, 64'h8000_0300, 0, 64'h8000_0200, 32'h4444_4444);
      add(0, 32'h0,        0, 0, 64'h0,          1, 0, 64'h8000_0300, 1, 64'h8000_0300, 32'h6666_6666);
      add(1, 32'h7777_7777, 0, 0, 64'h0,         0, 1, 64'h8000_0304, 0, 64'h8000_0300, 32'h6666_6666);
      add(0, 32'h0,        0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 64'h8000_0304, 0, 64'h8000_0304, 32'h7777_7777);
      add(0, 32'h0,        0, 1, WRAP,           0, 0, 64'h8000_0304, 0, 64'h8000_0304, 32'h7777_7777);
      add(0, 32'h0,        0, 0, 64'h0,          0, 0, 64'h8000_0304, 0, 64'h8000_0304, 32'h7777_7777);
      add(1, 32'h8888_8888, 0, 0, 64'h0,         1, 1, WRAP,          0, 64'h8000_0304, 32'h7777_7777);
      add(0, 32'h0,        0, 0, 64'h0,          1, 0, WRAP,          1, WRAP,          32'h8888_8888);
      add(0, 32'h0,        0, 0, 64'h0,          1, 1, 64'h0,         0, WRAP,          32'h8888_8888);

      resetn = 1'b0;
      drive(0, 32'h0, 0, 0, 64'h0, 0);
      repeat (2) @(negedge clk);
      chk_bus("reset", 0, 1'b0, 64'h8000_0000);
      chk("reset.out_valid", 0, 64'(out_valid), 64'h0);
      chk("reset.out_pc", 0, out_pc, 64'h8000_0000);
      chk("reset.out_instr", 0, 64'(out_instr), 64'h0);

      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].dok, vq[i].data, vq[i].hold, vq[i].rv, vq[i].rpc, vq[i].ordy);
         #1;
         chk_bus("vec", i, vq[i].e_v, vq[i].e_addr);
         chk("vec.out_valid", i, 64'(out_valid), 64'(vq[i].e_ov));
         chk("vec.out_pc", i, out_pc, vq[i].e_opc);
         chk("vec.out_instr", i, 64'(out_instr), 64'(vq[i].e_oi));
         @(negedge clk);
      end

      // Table ends with a request outstanding at 0; reset must drop it at once.
      drive(0, 32'h0, 0, 0, 64'h0, 1);
      #1;
      chk_bus("midreq_pre", 0, 1'b1, 64'h0);
      resetn = 1'b0;
      #1;
      chk_bus("midreq_rst", 0, 1'b0, 64'h8000_0000);
      chk("midreq_rst.out_valid", 0, 64'(out_valid), 64'h0);
      chk("midreq_rst.out_pc", 0, out_pc, 64'h8000_0000);
      chk("midreq_rst.out_instr", 0, 64'(out_instr), 64'h0);
      @(negedge clk);
      resetn = 1'b1;

      // Slow bus: five wait cycles, then one out_valid pulse.
      drive(0, 32'h0, 0, 0, 64'h0, 0);
      #1;
      chk_bus("slow_idle", 0, 1'b0, 64'h8000_0000);
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         #1;
         chk_bus("slow_wait", c, 1'b1, 64'h8000_0000);
         chk("slow_wait.out_valid", c, 64'(out_valid), 64'h0);
         @(negedge clk);
      end
      drive(1, 32'hAAAA_5555, 0, 0, 64'h0, 0);
      #1;
      chk_bus("slow_ok", 0, 1'b1, 64'h8000_0000);
      @(negedge clk);
      drive(0, 32'h0, 1, 0, 64'h0, 1);
      #1;
      chk("slow_hold.out_valid", 0, 64'(out_valid), 64'h1);
      chk("slow_hold.out_pc", 0, out_pc, 64'h8000_0000);
      chk("slow_hold.out_instr", 0, 64'(out_instr), 64'hAAAA_5555);
      @(negedge clk);

      // hold_fetch in IDLE for four cycles blocks the next fetch.
      drive(0, 32'h0, 1, 0, 64'h0, 0);
      for (int c = 0; c < 4; c++) begin
         #1;
         chk_bus("holdf", c, 1'b0, 64'h8000_0000);
         chk("holdf.out_valid", c, 64'(out_valid), 64'h0);
         @(negedge clk);
      end
      drive(0, 32'h0, 0, 0, 64'h0, 0);
      #1;
      chk_bus("holdf_fall", 0, 1'b0, 64'h8000_0000);
      @(negedge clk);
      #1;
      chk_bus("holdf_issue", 0, 1'b1, 64'h8000_0004);
      chk("holdf_issue.out_valid", 0, 64'(out_valid), 64'h0);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
